// File: rtl/mem_region_router_if.sv
// Upstream memory request channel (req/gnt/rvalid) between the AXI-to-mem bridge and mem_region_router.
interface mem_region_router_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 10
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [USER_W-1:0]     user;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata, user,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata, user,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_region_router.sv
// Address-window router for a req/gnt/rvalid channel with in-order response tracking.
// Define ROUTER_ERR_CNT_EN to build the saturating decode-error counter on err_cnt_o.
module mem_region_router #(
  parameter int unsigned NUM_REGIONS     = 2,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned USER_W          = 10,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_START = {64'h2000000, 64'h0},
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_END   = {64'h4000000, 64'h2000000},
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(64'hBADC0FFE_E0DDF00D)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  mem_region_router_if.slave            mst,
  output logic [NUM_REGIONS-1:0]        slv_req_o,
  output logic                          slv_we_o,
  output logic [DATA_W/8-1:0]           slv_be_o,
  output logic [ADDR_W-1:0]             slv_addr_o,
  output logic [DATA_W-1:0]             slv_wdata_o,
  output logic [USER_W-1:0]             slv_user_o,
  input  logic [NUM_REGIONS-1:0]        slv_gnt_i,
  input  logic [NUM_REGIONS-1:0]        slv_rvalid_i,
  input  logic [NUM_REGIONS*DATA_W-1:0] slv_rdata_i,
  output logic                          proto_err_o,
  output logic [15:0]                   err_cnt_o
);

  localparam int unsigned TAG_W = $clog2(NUM_REGIONS + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TAG_W-1:0] ERR_TAG  = TAG_W'(NUM_REGIONS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic                   hit;
  logic [TAG_W-1:0]       sel_tag;
  logic [NUM_REGIONS-1:0] hit_oh;
  logic [ADDR_W-1:0]      base;
  logic [TAG_W-1:0]       tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   full, empty, push, pop;
  logic [TAG_W-1:0]       head_tag;
  logic                   rvalid, err, grant;
  logic [DATA_W-1:0]      rdata;
  logic [NUM_REGIONS-1:0] head_oh;
  logic                   unexpected;
  logic                   proto_err_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Descending scan so the lowest matching window wins on overlap.
  always_comb begin
    hit     = 1'b0;
    sel_tag = ERR_TAG;
    hit_oh  = '0;
    base    = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (mst.addr >= REGION_START[k] && mst.addr < REGION_END[k]) begin
        hit     = 1'b1;
        sel_tag = TAG_W'(k);
        hit_oh  = NUM_REGIONS'(1) << k;
        base    = REGION_START[k];
      end
    end
  end

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign grant = mst.req & ~full & (hit ? |(slv_gnt_i & hit_oh) : 1'b1);
  assign push  = grant;
  assign pop   = rvalid;

  assign slv_req_o   = (mst.req & ~full) ? hit_oh : '0;
  assign slv_we_o    = mst.we;
  assign slv_be_o    = mst.be;
  assign slv_addr_o  = mst.addr - base;
  assign slv_wdata_o = mst.wdata;
  assign slv_user_o  = mst.user;

  assign head_tag = tag_mem[rd_ptr];

  // Only the slave at the FIFO head may respond; anything else is a protocol error.
  always_comb begin
    rvalid  = 1'b0;
    rdata   = '0;
    err     = 1'b0;
    head_oh = '0;
    if (!empty) begin
      if (head_tag == ERR_TAG) begin
        rvalid = 1'b1;
        rdata  = ERR_DATA;
        err    = 1'b1;
      end else begin
        for (int k = 0; k < NUM_REGIONS; k++) begin
          if (head_tag == TAG_W'(k)) begin
            rvalid     = slv_rvalid_i[k];
            rdata      = slv_rdata_i[k*DATA_W +: DATA_W];
            head_oh[k] = 1'b1;
          end
        end
      end
    end
  end

  assign unexpected = |(slv_rvalid_i & ~head_oh);

  assign mst.gnt    = grant;
  assign mst.rvalid = rvalid;
  assign mst.rdata  = rdata;
  assign mst.err    = err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (unexpected) proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= sel_tag;
  end

  assign proto_err_o = proto_err_q;

`ifdef ROUTER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          err_cnt_q <= '0;
    else if (grant && !hit) err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule
